// File: rtl/led_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// led_seq_ctrl_if
// Control/status bundle between top-level control logic and led_seq_ctrl.
//   cfg_we       : write cfg_pattern / cfg_len into the config registers
//   cfg_pattern  : pattern bits, bit k drives step k
//   cfg_len      : pattern length (0 or above PAT_LEN selects PAT_LEN)
//   cfg_loop     : 1 = repeat forever, 0 = one-shot (sampled at start)
//   cfg_duty     : LED brightness 0..15, present only with LED_DIM_EN
//   start / stop : single-cycle playback strobes
//   busy         : high while playing
//   done         : one-cycle pulse at the natural end of a one-shot run
//   step_idx     : index of the step currently displayed
// Modports: master (controller side), slave (led_seq_ctrl side).
// Optional macro: LED_DIM_EN adds cfg_duty.
// ---------------------------------------------------------------------------
interface led_seq_ctrl_if #(
    parameter int PAT_LEN = 10,
    parameter int LEN_W   = 4
);
    logic               cfg_we;
    logic [PAT_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_loop;
`ifdef LED_DIM_EN
    logic [3:0]         cfg_duty;
`endif
    logic               start;
    logic               stop;
    logic               busy;
    logic               done;
    logic [LEN_W-1:0]   step_idx;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_loop, start, stop,
`ifdef LED_DIM_EN
        output cfg_duty,
`endif
        input  busy, done, step_idx
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_loop, start, stop,
`ifdef LED_DIM_EN
        input  cfg_duty,
`endif
        output busy, done, step_idx
    );
endinterface

// File: rtl/led_seq_ctrl.sv
// ---------------------------------------------------------------------------
// led_seq_ctrl
// Plays a programmable on/off bit pattern on the LED bank, one pattern bit
// per step, each step lasting TICK_DIV clock cycles. One-shot or loop mode.
// Ports:
//   CLK    : system clock
//   RST_N  : asynchronous active-low reset
//   bus    : led_seq_ctrl_if.slave (config, start/stop, busy/done/step_idx)
//   LED    : NUM_LEDS outputs, all equal to the current pattern bit while
//            playing, 0 otherwise
// Optional macro: LED_DIM_EN adds a 4-bit PWM dimmer (bus.cfg_duty).
// All outputs are registered.
// ---------------------------------------------------------------------------
module led_seq_ctrl #(
    parameter int                TICK_DIV = 1200000,
    parameter int                PAT_LEN  = 10,
    parameter logic [PAT_LEN-1:0] PAT_INIT = 10'b1010000000,
    parameter int                NUM_LEDS = 5,
    parameter int                LEN_W    = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    led_seq_ctrl_if.slave       bus,
    output logic [NUM_LEDS-1:0] LED
);
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_LEN);

    // Out-of-range lengths are folded to the full pattern when written.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len == '0 || len > LEN_MAX) ? LEN_MAX : len;
    endfunction

    state_t               state_q, state_d;
    logic [PAT_LEN-1:0]   cfg_pat_q, cfg_pat_d;
    logic [LEN_W-1:0]     cfg_len_q, cfg_len_d;
    logic [PAT_LEN-1:0]   sh_pat_q, sh_pat_d;
    logic [LEN_W-1:0]     sh_len_q, sh_len_d;
    logic                 loop_q, loop_d;
    logic [LEN_W-1:0]     step_q, step_d;
    logic [PRE_W-1:0]     presc_q, presc_d;
    logic [NUM_LEDS-1:0]  led_q, led_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 lit;
`ifdef LED_DIM_EN
    logic [3:0]           duty_q, duty_d;
    logic [3:0]           pwm_q, pwm_d;
`endif

    always_comb begin
        state_d   = state_q;
        cfg_pat_d = cfg_pat_q;
        cfg_len_d = cfg_len_q;
        sh_pat_d  = sh_pat_q;
        sh_len_d  = sh_len_q;
        loop_d    = loop_q;
        step_d    = step_q;
        presc_d   = presc_q;
`ifdef LED_DIM_EN
        duty_d    = duty_q;
        pwm_d     = pwm_q + 4'd1;
`endif

        if (bus.cfg_we) begin
            cfg_pat_d = bus.cfg_pattern;
            cfg_len_d = clamp_len(bus.cfg_len);
        end

        if (bus.stop) begin
            state_d = S_IDLE;
            step_d  = '0;
            presc_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_d = S_IDLE;
                    step_d  = '0;
                    presc_d = '0;
                    if (bus.start) begin
                        // Shadows take the _d config so a same-cycle write is seen.
                        state_d  = S_PLAY;
                        sh_pat_d = cfg_pat_d;
                        sh_len_d = cfg_len_d;
                        loop_d   = bus.cfg_loop;
`ifdef LED_DIM_EN
                        duty_d   = bus.cfg_duty;
`endif
                    end
                end
                S_PLAY: begin
                    if (presc_q == PRE_LAST) begin
                        presc_d = '0;
                        if (step_q == sh_len_q - LEN_W'(1)) begin
                            step_d = '0;
                            if (!loop_q) state_d = S_DONE;
                        end else begin
                            step_d = step_q + LEN_W'(1);
                        end
                    end else begin
                        presc_d = presc_q + PRE_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    step_d  = '0;
                    presc_d = '0;
                end
            endcase
        end

        // Outputs are computed from next-state values so they stay registered.
        busy_d = (state_d == S_PLAY);
        done_d = (state_d == S_DONE);
        lit    = busy_d && sh_pat_d[step_d];
`ifdef LED_DIM_EN
        led_d  = {NUM_LEDS{lit && (pwm_d < duty_d)}};
`else
        led_d  = {NUM_LEDS{lit}};
`endif
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            cfg_pat_q <= PAT_INIT;
            cfg_len_q <= LEN_MAX;
            sh_pat_q  <= PAT_INIT;
            sh_len_q  <= LEN_MAX;
            loop_q    <= 1'b0;
            step_q    <= '0;
            presc_q   <= '0;
            led_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef LED_DIM_EN
            duty_q    <= '0;
            pwm_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cfg_pat_q <= cfg_pat_d;
            cfg_len_q <= cfg_len_d;
            sh_pat_q  <= sh_pat_d;
            sh_len_q  <= sh_len_d;
            loop_q    <= loop_d;
            step_q    <= step_d;
            presc_q   <= presc_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef LED_DIM_EN
            duty_q    <= duty_d;
            pwm_q     <= pwm_d;
`endif
        end
    end

    assign LED          = led_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.step_idx = step_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_seq_ctrl
// Directed bench for led_seq_ctrl with TICK_DIV=4 (one step = 4 cycles).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_led_seq_ctrl;
    logic       clk;
    logic       rst_n;
    logic [4:0] led;
    int         checks;
    int         failures;

    led_seq_ctrl_if #(.PAT_LEN(10), .LEN_W(4)) bus ();

    led_seq_ctrl #(
        .TICK_DIV (4),
        .PAT_LEN  (10),
        .PAT_INIT (10'b1010000000),
        .NUM_LEDS (5),
        .LEN_W    (4)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus.slave),
        .LED   (led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    task automatic write_cfg(input logic [9:0] pat, input logic [3:0] len, input logic lp);
        bus.cfg_we      = 1'b1;
        bus.cfg_pattern = pat;
        bus.cfg_len     = len;
        bus.cfg_loop    = lp;
        step();
        bus.cfg_we      = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] pat;
        logic [4:0] exp;
        pat = 10'b1010000000;
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if (led !== 5'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.step_idx !== 4'd0) begin
            failures++;
            $display("FAIL reset_state led=%b busy=%b done=%b step=%0d, want 00000/0/0/0",
                     led, bus.busy, bus.done, bus.step_idx);
        end
        rst_n = 1'b1;
        step();
        // Start without configuring: plays PAT_INIT over 10 steps.
        pulse_start();
        for (int c = 0; c < 40; c++) begin
            exp = pat[c/4] ? 5'b11111 : 5'b00000;
            checks++;
            if (led !== exp || bus.busy !== 1'b1 || bus.step_idx !== 4'(c/4)) begin
                failures++;
                $display("FAIL reset_init_play c=%0d led=%b busy=%b step=%0d, want led=%b busy=1 step=%0d",
                         c, led, bus.busy, bus.step_idx, exp, c/4);
            end
            step();
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_init_done done=%b busy=%b, want 1/0", bus.done, bus.busy);
        end
        step();
        // Mid-run reset while a lit step is shown.
        pulse_start();
        repeat (28) step();
        checks++;
        if (led !== 5'b11111 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_lit led=%b busy=%b, want 11111/1", led, bus.busy);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 5'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.step_idx !== 4'd0) begin
            failures++;
            $display("FAIL reset_async led=%b busy=%b done=%b step=%0d, want 00000/0/0/0",
                     led, bus.busy, bus.done, bus.step_idx);
        end
        #1 rst_n = 1'b1;
        step();
        repeat (15) begin
            checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || led !== 5'b0) begin
                failures++;
                $display("FAIL reset_after busy=%b done=%b led=%b, want 0/0/00000", bus.busy, bus.done, led);
            end
            step();
        end
    endtask

    task automatic test_oneshot();
        logic [9:0] pat;
        logic [4:0] exp;
        pat = 10'b1010000000;
        write_cfg(pat, 4'd0, 1'b0);
        pulse_start();
        for (int c = 0; c < 40; c++) begin
            exp = pat[c/4] ? 5'b11111 : 5'b00000;
            checks++;
            if (led !== exp || bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.step_idx !== 4'(c/4)) begin
                failures++;
                $display("FAIL oneshot c=%0d led=%b busy=%b done=%b step=%0d, want led=%b busy=1 done=0 step=%0d",
                         c, led, bus.busy, bus.done, bus.step_idx, exp, c/4);
            end
            step();
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || led !== 5'b0 || bus.step_idx !== 4'd0) begin
            failures++;
            $display("FAIL oneshot_done done=%b busy=%b led=%b step=%0d, want 1/0/00000/0",
                     bus.done, bus.busy, led, bus.step_idx);
        end
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_after done=%b busy=%b, want 0/0", bus.done, bus.busy);
        end
    endtask

    task automatic test_loop();
        logic [9:0] pat;
        logic [4:0] exp;
        int         k;
        pat = 10'b0000000101;
        write_cfg(pat, 4'd3, 1'b1);
        pulse_start();
        for (int c = 0; c < 48; c++) begin
            k = (c / 4) % 3;
            exp = pat[k] ? 5'b11111 : 5'b00000;
            checks++;
            if (led !== exp || bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.step_idx !== 4'(k)) begin
                failures++;
                $display("FAIL loop c=%0d led=%b busy=%b done=%b step=%0d, want led=%b busy=1 done=0 step=%0d",
                         c, led, bus.busy, bus.done, bus.step_idx, exp, k);
            end
            step();
        end
        pulse_stop();
        checks++;
        if (bus.busy !== 1'b0 || led !== 5'b0 || bus.done !== 1'b0 || bus.step_idx !== 4'd0) begin
            failures++;
            $display("FAIL loop_stop busy=%b led=%b done=%b step=%0d, want 0/00000/0/0",
                     bus.busy, led, bus.done, bus.step_idx);
        end
    endtask

    task automatic test_stop();
        logic seen;
        write_cfg(10'b1111111111, 4'd0, 1'b0);
        pulse_start();
        repeat (21) step();
        checks++;
        if (bus.step_idx !== 4'd5 || led !== 5'b11111) begin
            failures++;
            $display("FAIL stop_pre step=%0d led=%b, want 5/11111", bus.step_idx, led);
        end
        pulse_stop();
        checks++;
        if (led !== 5'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.step_idx !== 4'd0) begin
            failures++;
            $display("FAIL stop_next led=%b busy=%b done=%b step=%0d, want 00000/0/0/0",
                     led, bus.busy, bus.done, bus.step_idx);
        end
        seen = 1'b0;
        repeat (30) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
            step();
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL stop_no_done activity_seen=%b, want 0", seen);
        end
    endtask

    task automatic test_stop_start();
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || led !== 5'b0 || bus.step_idx !== 4'd0) begin
            failures++;
            $display("FAIL stop_start busy=%b led=%b step=%0d, want 0/00000/0", bus.busy, led, bus.step_idx);
        end
        repeat (5) step();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL stop_start_later busy=%b, want 0", bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        // Config still holds all ones / full length / one-shot.
        pulse_start();
        repeat (9) step();
        checks++;
        if (bus.step_idx !== 4'd2) begin
            failures++;
            $display("FAIL replay_pre step=%0d, want 2", bus.step_idx);
        end
        pulse_start();
        checks++;
        if (bus.step_idx !== 4'd2 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL replay_ignored step=%0d busy=%b, want 2/1", bus.step_idx, bus.busy);
        end
        repeat (2) step();
        checks++;
        if (bus.step_idx !== 4'd3) begin
            failures++;
            $display("FAIL replay_advance step=%0d, want 3", bus.step_idx);
        end
        pulse_stop();
    endtask

    task automatic test_cfg_bypass();
        logic [9:0] pat;
        logic [4:0] exp;
        pat = 10'b1100000001;
        bus.cfg_we      = 1'b1;
        bus.cfg_pattern = pat;
        bus.cfg_len     = 4'd15;
        bus.cfg_loop    = 1'b0;
        bus.start       = 1'b1;
        step();
        bus.cfg_we      = 1'b0;
        bus.start       = 1'b0;
        for (int c = 0; c < 40; c++) begin
            exp = pat[c/4] ? 5'b11111 : 5'b00000;
            checks++;
            if (led !== exp || bus.busy !== 1'b1 || bus.step_idx !== 4'(c/4)) begin
                failures++;
                $display("FAIL bypass c=%0d led=%b busy=%b step=%0d, want led=%b busy=1 step=%0d",
                         c, led, bus.busy, bus.step_idx, exp, c/4);
            end
            step();
        end
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL bypass_done done=%b, want 1", bus.done);
        end
        step();
    endtask

    task automatic test_cfg_midrun();
        logic [9:0] pa;
        logic [9:0] pb;
        logic [4:0] exp;
        pa = 10'b0000000011;
        pb = 10'b0000000010;
        write_cfg(pa, 4'd2, 1'b0);
        pulse_start();
        for (int c = 0; c < 8; c++) begin
            exp = pa[c/4] ? 5'b11111 : 5'b00000;
            checks++;
            if (led !== exp || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL midrun_cur c=%0d led=%b busy=%b, want %b/1", c, led, bus.busy, exp);
            end
            if (c == 2) begin
                bus.cfg_we      = 1'b1;
                bus.cfg_pattern = pb;
                bus.cfg_len     = 4'd2;
            end
            step();
            bus.cfg_we = 1'b0;
        end
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL midrun_done done=%b, want 1", bus.done);
        end
        step();
        pulse_start();
        for (int c = 0; c < 8; c++) begin
            exp = pb[c/4] ? 5'b11111 : 5'b00000;
            checks++;
            if (led !== exp || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL midrun_next c=%0d led=%b busy=%b, want %b/1", c, led, bus.busy, exp);
            end
            step();
        end
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL midrun_next_done done=%b, want 1", bus.done);
        end
        step();
    endtask

`ifdef LED_DIM_EN
    task automatic test_dim();
        int on_cnt;
        int odd_cnt;
        bus.cfg_duty = 4'd4;
        write_cfg(10'b1111111111, 4'd0, 1'b1);
        pulse_start();
        on_cnt  = 0;
        odd_cnt = 0;
        repeat (32) begin
            if (led === 5'b11111) on_cnt++;
            else if (led !== 5'b00000) odd_cnt++;
            step();
        end
        checks++;
        if (on_cnt != 8 || odd_cnt != 0) begin
            failures++;
            $display("FAIL dim_duty4 on=%0d partial=%0d, want 8/0", on_cnt, odd_cnt);
        end
        pulse_stop();
        bus.cfg_duty = 4'd0;
        pulse_start();
        on_cnt = 0;
        repeat (32) begin
            if (led !== 5'b00000) on_cnt++;
            step();
        end
        checks++;
        if (on_cnt != 0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL dim_duty0 lit_cycles=%0d busy=%b, want 0/1", on_cnt, bus.busy);
        end
        pulse_stop();
    endtask
`endif

    initial begin
        checks          = 0;
        failures        = 0;
        rst_n           = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        bus.cfg_loop    = 1'b0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
`ifdef LED_DIM_EN
        bus.cfg_duty    = 4'd0;
`endif
        test_reset();
        test_oneshot();
        test_loop();
        test_stop();
        test_stop_start();
        test_back_to_back();
        test_cfg_bypass();
        test_cfg_midrun();
`ifdef LED_DIM_EN
        test_dim();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
